// File: rtl/reset_sequencer.sv
// Board-level reset sequencer: synchronizes and debounces a push-button and
// produces a held, registered active-low reset plus button status outputs.
module reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       btn,
  output logic       resetn,
  output logic       btn_level,
  output logic       btn_press,
  output logic [7:0] reset_count
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic          IDLE_RAW  = BTN_ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PRESSED = 2'd2
  } state_e;

  logic          sync1_q, sync2_q;
  logic          btn_sync_s;
  logic [DW-1:0] deb_q, deb_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          resetn_q, resetn_d;
  logic [7:0]    count_q, count_d;

  assign btn_sync_s = sync2_q ^ BTN_ACTIVE_LOW;

  // Debounce counter, level toggle and press pulse
  always_comb begin
    deb_d   = {DW{1'b0}};
    level_d = level_q;
    press_d = 1'b0;
    if (btn_sync_s == level_q) begin
      deb_d = {DW{1'b0}};
    end else if (deb_q == DEB_LAST) begin
      level_d = ~level_q;
      press_d = ~level_q;
      deb_d   = {DW{1'b0}};
    end else begin
      deb_d = deb_q + DW'(1);
    end
  end

  // Sequencer FSM next state and registered-output values
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    resetn_d = resetn_q;
    count_d  = count_q;
    case (state_q)
      ST_HOLD: begin
        resetn_d = 1'b0;
        if (level_q) begin
          state_d = ST_PRESSED;
          hold_d  = {HW{1'b0}};
        end else if (hold_q == HOLD_LAST) begin
          state_d  = ST_RUN;
          resetn_d = 1'b1;
          hold_d   = {HW{1'b0}};
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_RUN: begin
        resetn_d = 1'b1;
        if (level_q) begin
          state_d  = ST_PRESSED;
          resetn_d = 1'b0;
          count_d  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PRESSED: begin
        resetn_d = 1'b0;
        hold_d   = {HW{1'b0}};
        // The exit edge is the first hold cycle (count 0), so resetn rises
        // HOLD_CYCLES edges after the debounced release.
        if (!level_q) begin
          if (HOLD_LAST == {HW{1'b0}}) begin
            state_d  = ST_RUN;
            resetn_d = 1'b1;
          end else begin
            state_d = ST_HOLD;
            hold_d  = HW'(1);
          end
        end else begin
          state_d = ST_PRESSED;
        end
      end
      default: begin
        state_d  = ST_HOLD;
        resetn_d = 1'b0;
        hold_d   = {HW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q  <= IDLE_RAW;
      sync2_q  <= IDLE_RAW;
      deb_q    <= {DW{1'b0}};
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      state_q  <= ST_HOLD;
      hold_q   <= {HW{1'b0}};
      resetn_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      level_q  <= level_d;
      press_q  <= press_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      resetn_q <= resetn_d;
      count_q  <= count_d;
    end
  end

  assign resetn      = resetn_q;
  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign reset_count = count_q;

endmodule
